uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_REQ, 4, number of requesters, 2..8
- FRAME_WIDTH, 8, UART data width
- TIMEOUT_CYCLES, 1024, idle-grant limit, used only under REQ-019
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock
- reset_n, in, 1, asynchronous active-low reset
- req_valid, in, NUM_REQ, requester has a byte
- req_data, in, NUM_REQ*FRAME_WIDTH, byte per requester; requester i at [i*FRAME_WIDTH +: FRAME_WIDTH]
- req_last, in, NUM_REQ, byte is the last of the packet
- req_ready, out, NUM_REQ, byte accepted this cycle when valid
- wr_uart, out, 1, UART TX FIFO write strobe
- w_data, out, FRAME_WIDTH, UART TX FIFO write data
- tx_full, in, 1, UART TX FIFO full
- grant, out, NUM_REQ, one-hot current owner
- busy, out, 1, a packet is in progress
- timeout_err, out, 1, one-cycle pulse on forced release

Function
REQ-003 The FSM SHALL have two states, IDLE and OWN, encoded in 1 bit.
REQ-004 In IDLE with any req_valid high, the block SHALL pick a winner round-robin: the first set bit searching upward (with wrap) from rr_ptr. It SHALL register grant to that one-hot value and enter OWN on the next edge.
REQ-005 In IDLE, grant and req_ready SHALL be all-zero, and wr_uart SHALL be 0.
REQ-006 In OWN, req_ready[g] SHALL equal ~tx_full combinationally; all other req_ready bits SHALL be 0.
REQ-007 A transfer SHALL occur when req_valid[g] && req_ready[g]. During it, wr_uart SHALL be 1 and w_data SHALL equal req_data of g, both combinational and in the same cycle.
REQ-008 When wr_uart is 0, w_data SHALL be all-zero.
REQ-009 A transfer with req_last[g] set SHALL return the FSM to IDLE, clear grant and set rr_ptr to (g+1) mod NUM_REQ on that edge.
REQ-010 Latency: first byte no earlier than 1 cycle after req_valid is seen in IDLE. Steady state is 1 byte/cycle while tx_full is 0.
REQ-011 While tx_full is high, transfers SHALL stall and grant SHALL be held; no byte is dropped or duplicated.
REQ-012 If req_valid[g] drops mid-packet, grant SHALL be held (subject to REQ-019).
REQ-013 Requests from non-owners SHALL be ignored until IDLE; no pre-emption.
REQ-014 When several requesters are valid simultaneously, the winner SHALL be the first at or after rr_ptr.
REQ-015 busy SHALL equal (state == OWN).
REQ-016 Single-byte packets (req_last set on the first byte) SHALL take one OWN cycle. No idle cycles between packets are required beyond the IDLE arbitration cycle.

Reset
REQ-017 While reset_n is low: state SHALL be IDLE, grant 0, rr_ptr 0, timeout counter 0, timeout_err 0. As a consequence, busy, req_ready and wr_uart are 0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet with no further wr_uart. After release, arbitration SHALL restart from requester 0.

Configuration
REQ-019 With UART_ARB_TIMEOUT_EN defined:
- A counter SHALL count consecutive OWN cycles in which req_valid[g] is 0 (cleared on any transfer or on entering OWN).
- On reaching TIMEOUT_CYCLES-1 the block SHALL force IDLE, set rr_ptr to g+1, and pulse timeout_err high for 1 cycle.
REQ-020 Without UART_ARB_TIMEOUT_EN: no counter SHALL be synthesized, timeout_err SHALL be tied 0, and grant SHALL be held indefinitely.

Structure
REQ-021 A shared package uart_pkg SHALL hold:
- the state typedef (IDLE/OWN)
- FRAME_WIDTH default
- a clog2-based pointer width constant
REQ-022 The round-robin picker SHALL be a sub-module rr_picker (combinational: req, ptr -> one-hot win).

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Req0 sends a 3-byte packet AA,4C,B9 (last on B9), tx_full=0 -> wr_uart high 3 consecutive cycles with those bytes; busy drops the cycle after B9.
- Req0..3 all valid, 1-byte packets each -> grant order 0,1,2,3; then the next round starts at 0; each winner's byte appears once.
- tx_full high for 5 cycles mid-packet (owner req2, byte F0 pending) -> req_ready[2]=0 and wr_uart=0 for those 5 cycles; F0 written exactly once after tx_full falls.
- Reset pulse while req1 owns after its 2nd of 4 bytes -> no wr_uart during reset; afterwards req1 and req3 both valid -> req1 wins (rr_ptr=0).
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, owner req3 drops valid mid-packet -> timeout_err pulses at OWN idle cycle 16; pending req0 is granted next.
- Without the macro, same stimulus -> grant to req3 held for 100+ cycles, timeout_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg (package)
// Description : Shared types and constants for the UART TX arbiter slice.
//               - state_t        : arbiter FSM state (IDLE / OWN), 1 bit
//               - c_frame_width  : default UART data width
//               - c_max_req      : largest supported requester count
//               - c_ptr_w        : round-robin pointer / owner index width
//               - onehot_to_idx  : one-hot to binary index helper
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int c_frame_width = 8;
    localparam int c_max_req     = 8;
    localparam int c_ptr_w       = $clog2(c_max_req);

    // Binary index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [c_ptr_w-1:0] onehot_to_idx(input logic [c_max_req-1:0] oh);
        logic [c_ptr_w-1:0] idx;
        idx = '0;
        for (int i = 0; i < c_max_req; i++) begin
            if (oh[i]) begin
                idx = c_ptr_w'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Returns the first set bit
//               of req searching upward from ptr, wrapping to bit 0.
// Ports       : req [NUM_REQ]  - request vector
//               ptr [c_ptr_w]  - search start position (< NUM_REQ)
//               win [NUM_REQ]  - one-hot winner, all-zero if no request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [c_ptr_w-1:0] ptr,
    output logic [NUM_REQ-1:0] win
);

    logic [NUM_REQ-1:0] w_upper_mask;
    logic [NUM_REQ-1:0] w_upper_req;
    logic [NUM_REQ-1:0] w_search;

    // Requests at or above ptr take priority; if none exist the search wraps
    // and the lowest request overall wins. Lowest set bit is isolated with
    // x & -x.
    assign w_upper_mask = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    assign w_upper_req  = req & w_upper_mask;
    assign w_search     = (|w_upper_req) ? w_upper_req : req;
    assign win          = w_search & (~w_search + NUM_REQ'(1));

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter letting NUM_REQ packet sources share one
//               UART TX FIFO. A winner owns the FIFO until it transfers a
//               byte flagged req_last; no pre-emption.
// Ports       : clk, reset_n (async, active low)
//               req_valid/req_data/req_last/req_ready - requester side
//               wr_uart/w_data/tx_full                - UART TX FIFO side
//               grant, busy, timeout_err              - status
// Config      : UART_ARB_TIMEOUT_EN - when defined, an owner that keeps
//               req_valid low for TIMEOUT_CYCLES consecutive OWN cycles is
//               forcibly released and timeout_err pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int FRAME_WIDTH    = c_frame_width,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FRAME_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wr_uart,
    output logic [FRAME_WIDTH-1:0]         w_data,
    input  logic                           tx_full,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic                           timeout_err
);

    state_t                 r_state;
    logic [c_ptr_w-1:0]     r_rr_ptr;
    logic [c_ptr_w-1:0]     r_owner;

    logic [NUM_REQ-1:0]     w_win;
    logic [c_max_req-1:0]   w_win_ext;
    logic [FRAME_WIDTH-1:0] w_owner_data;
    logic                   w_xfer;
    logic                   w_last_xfer;
    logic                   w_owner_idle;
    logic                   w_timeout;
    logic [c_ptr_w-1:0]     w_next_ptr;

    // Out-of-range configurations elaborate this empty marker block so the
    // condition is visible in elaboration reports.
    if (NUM_REQ < 2 || NUM_REQ > c_max_req || TIMEOUT_CYCLES < 2) begin : g_bad_config
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .win (w_win)
    );

    always_comb begin
        w_win_ext                = '0;
        w_win_ext[NUM_REQ-1:0]   = w_win;
    end

    always_comb begin
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                w_owner_data = req_data[i*FRAME_WIDTH +: FRAME_WIDTH];
            end
        end
    end

    // grant is all-zero outside OWN, so masking by it alone gates req_ready.
    assign req_ready    = (r_state == OWN && !tx_full) ? grant : '0;
    assign w_xfer       = |(req_valid & req_ready);
    assign w_last_xfer  = |(req_valid & req_ready & req_last);
    assign w_owner_idle = ~|(req_valid & grant);
    assign wr_uart      = w_xfer;
    assign w_data       = w_xfer ? w_owner_data : '0;
    assign busy         = (r_state == OWN);
    assign w_next_ptr   = (r_owner == c_ptr_w'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES);

    logic [c_to_w-1:0] r_idle_cnt;

    // Fires in the TIMEOUT_CYCLES-th consecutive cycle the owner is idle.
    assign w_timeout = (r_state == OWN) && w_owner_idle &&
                       (r_idle_cnt == c_to_w'(TIMEOUT_CYCLES - 1));

    // Any cycle that is not an idle OWN cycle (transfer, stall with valid
    // high, IDLE) breaks the run, so the counter restarts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= w_timeout;
            if (r_state == OWN && w_owner_idle && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            grant    <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        grant   <= w_win;
                        r_owner <= onehot_to_idx(w_win_ext);
                        r_state <= OWN;
                    end
                end
                OWN: begin
                    if (w_last_xfer || w_timeout) begin
                        grant    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    grant   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//               FRAME_WIDTH=8, TIMEOUT_CYCLES=16). Inputs change 2 time units
//               after each rising edge; outputs are checked 1 unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int FW = 8;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            wr_uart;
    logic [FW-1:0]   w_data;
    logic            tx_full;
    logic [N-1:0]    grant;
    logic            busy;
    logic            timeout_err;

    int compared;
    int mismatched;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .FRAME_WIDTH    (FW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .wr_uart     (wr_uart),
        .w_data      (w_data),
        .tx_full     (tx_full),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int lane, input logic [FW-1:0] d);
        req_data[lane*FW +: FW] = d;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
        step();
        req_valid = 4'b1111;
        step();
        #1;
        compared++; if (grant !== 4'b0000) begin mismatched++; $display("FAIL reset_grant: got %b want 0000", grant); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if (req_ready !== 4'b0000 || wr_uart !== 1'b0 || w_data !== 8'h00) begin mismatched++; $display("FAIL reset_outputs: got ready=%b wr=%b data=%h want 0000/0/00", req_ready, wr_uart, w_data); end
        compared++; if (timeout_err !== 1'b0) begin mismatched++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        req_valid = '0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_three_byte();
        req_valid = 4'b0001; set_data(0, 8'hAA); req_last = 4'b0000;
        #1;
        compared++; if (grant !== 4'b0000 || wr_uart !== 1'b0 || req_ready !== 4'b0000) begin mismatched++; $display("FAIL idle_outputs: got grant=%b wr=%b ready=%b want 0000/0/0000", grant, wr_uart, req_ready); end
        step(); #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'hAA || busy !== 1'b1) begin mismatched++; $display("FAIL pkt_byte0: got wr=%b data=%h busy=%b want 1/aa/1", wr_uart, w_data, busy); end
        compared++; if (req_ready !== 4'b0001 || grant !== 4'b0001) begin mismatched++; $display("FAIL pkt_grant: got ready=%b grant=%b want 0001/0001", req_ready, grant); end
        step(); set_data(0, 8'h4C); #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'h4C) begin mismatched++; $display("FAIL pkt_byte1: got wr=%b data=%h want 1/4c", wr_uart, w_data); end
        step(); set_data(0, 8'hB9); req_last = 4'b0001; #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'hB9) begin mismatched++; $display("FAIL pkt_byte2: got wr=%b data=%h want 1/b9", wr_uart, w_data); end
        step(); req_valid = '0; req_last = '0; #1;
        compared++; if (busy !== 1'b0 || grant !== 4'b0000 || wr_uart !== 1'b0 || w_data !== 8'h00) begin mismatched++; $display("FAIL pkt_end: got busy=%b grant=%b wr=%b data=%h want 0/0000/0/00", busy, grant, wr_uart, w_data); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        req_valid = 4'b1111; req_last = 4'b1111;
        for (int i = 0; i < N; i++) set_data(i, 8'hC0 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % N);
            #1;
            compared++; if (grant !== 4'b0000 || wr_uart !== 1'b0) begin mismatched++; $display("FAIL rr_idle%0d: got grant=%b wr=%b want 0000/0", k, grant, wr_uart); end
            step(); #1;
            compared++; if (grant !== exp_g || wr_uart !== 1'b1 || w_data !== 8'hC0 + 8'(k % N)) begin mismatched++; $display("FAIL rr_win%0d: got grant=%b wr=%b data=%h want %b/1/%h", k, grant, wr_uart, w_data, exp_g, 8'hC0 + 8'(k % N)); end
            step();
        end
        req_valid = '0; req_last = '0;
    endtask

    task automatic test_tx_full_stall();
        int writes;
        writes = 0;
        req_valid = 4'b0100; set_data(2, 8'h11); req_last = 4'b0000;
        step(); #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'h11 || grant !== 4'b0100) begin mismatched++; $display("FAIL stall_first: got wr=%b data=%h grant=%b want 1/11/0100", wr_uart, w_data, grant); end
        step(); set_data(2, 8'hF0); req_last = 4'b0100; tx_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            compared++; if (req_ready !== 4'b0000 || wr_uart !== 1'b0 || grant !== 4'b0100) begin mismatched++; $display("FAIL stall_cycle%0d: got ready=%b wr=%b grant=%b want 0000/0/0100", c, req_ready, wr_uart, grant); end
            step();
        end
        tx_full = 1'b0; #1;
        if (wr_uart === 1'b1 && w_data === 8'hF0) writes++;
        compared++; if (req_ready !== 4'b0100 || wr_uart !== 1'b1 || w_data !== 8'hF0) begin mismatched++; $display("FAIL stall_release: got ready=%b wr=%b data=%h want 0100/1/f0", req_ready, wr_uart, w_data); end
        step(); #1;
        if (wr_uart === 1'b1) writes++;
        req_valid = '0; req_last = '0;
        compared++; if (writes !== 1 || busy !== 1'b0) begin mismatched++; $display("FAIL stall_once: got writes=%0d busy=%b want 1/0", writes, busy); end
    endtask

    task automatic test_reset_mid_packet();
        req_valid = 4'b0010; set_data(1, 8'h21); req_last = 4'b0000;
        step(); #1;
        compared++; if (grant !== 4'b0010 || w_data !== 8'h21) begin mismatched++; $display("FAIL rst_pkt_b0: got grant=%b data=%h want 0010/21", grant, w_data); end
        step(); set_data(1, 8'h22); #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'h22) begin mismatched++; $display("FAIL rst_pkt_b1: got wr=%b data=%h want 1/22", wr_uart, w_data); end
        step(); set_data(1, 8'h23);
        reset_n = 1'b0; #1;
        compared++; if (wr_uart !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin mismatched++; $display("FAIL rst_async: got wr=%b busy=%b grant=%b want 0/0/0000", wr_uart, busy, grant); end
        step(); #1;
        compared++; if (wr_uart !== 1'b0) begin mismatched++; $display("FAIL rst_hold: got wr=%b want 0", wr_uart); end
        step();
        reset_n = 1'b1;
        req_valid = 4'b1010; req_last = 4'b1010; set_data(1, 8'h31); set_data(3, 8'h33); #1;
        compared++; if (busy !== 1'b0 || wr_uart !== 1'b0) begin mismatched++; $display("FAIL rst_after_idle: got busy=%b wr=%b want 0/0", busy, wr_uart); end
        step(); #1;
        compared++; if (grant !== 4'b0010 || w_data !== 8'h31) begin mismatched++; $display("FAIL rst_restart_ptr: got grant=%b data=%h want 0010/31", grant, w_data); end
        step();
        req_valid = '0; req_last = '0;
        step();
    endtask

    task automatic test_timeout();
        req_valid = 4'b1000; set_data(3, 8'h5A); req_last = 4'b0000;
        step(); #1;
        compared++; if (grant !== 4'b1000 || wr_uart !== 1'b1 || w_data !== 8'h5A) begin mismatched++; $display("FAIL to_first: got grant=%b wr=%b data=%h want 1000/1/5a", grant, wr_uart, w_data); end
        step();
        req_valid = 4'b0001; set_data(0, 8'h77); req_last = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            #1;
            compared++; if (grant !== 4'b1000 || timeout_err !== 1'b0) begin mismatched++; $display("FAIL to_idle%0d: got grant=%b terr=%b want 1000/0", i, grant, timeout_err); end
            step();
        end
        #1;
        compared++; if (timeout_err !== 1'b1 || busy !== 1'b0 || grant !== 4'b0000) begin mismatched++; $display("FAIL to_pulse: got terr=%b busy=%b grant=%b want 1/0/0000", timeout_err, busy, grant); end
        step(); #1;
        compared++; if (timeout_err !== 1'b0 || grant !== 4'b0001 || w_data !== 8'h77) begin mismatched++; $display("FAIL to_next: got terr=%b grant=%b data=%h want 0/0001/77", timeout_err, grant, w_data); end
        step();
        req_valid = '0; req_last = '0;
`else
        for (int i = 1; i <= 120; i++) begin
            #1;
            compared++; if (grant !== 4'b1000 || timeout_err !== 1'b0) begin mismatched++; $display("FAIL hold_idle%0d: got grant=%b terr=%b want 1000/0", i, grant, timeout_err); end
            step();
        end
        req_valid = 4'b1001; set_data(3, 8'h5B); req_last = 4'b1001; #1;
        compared++; if (wr_uart !== 1'b1 || w_data !== 8'h5B || req_ready !== 4'b1000) begin mismatched++; $display("FAIL hold_resume: got wr=%b data=%h ready=%b want 1/5b/1000", wr_uart, w_data, req_ready); end
        step();
        req_valid = 4'b0001;
        step(); #1;
        compared++; if (grant !== 4'b0001 || w_data !== 8'h77) begin mismatched++; $display("FAIL hold_next: got grant=%b data=%h want 0001/77", grant, w_data); end
        step();
        req_valid = '0; req_last = '0;
`endif
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_three_byte();
        test_round_robin();
        test_tx_full_stall();
        test_reset_mid_packet();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
